// File: rtl/mux_rr_sel.sv
// mux_rr_sel: N-channel registered multiplexer with per-channel valid/ready.
// Two modes: fixed select (channel = sel) or round-robin among valid channels.
// One output register stage; no combinational path from in_* to out_*.
// Optional: define MUX_RR_SEL_ERR_EN to add the sticky sel_err output, which
// flags fixed-mode selection of a nonexistent channel while any input is valid.
module mux_rr_sel #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
`ifdef MUX_RR_SEL_ERR_EN
    ,
    output logic                     sel_err
`endif
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_cand;
    logic              rr_found;
    logic              sel_ok;
    logic              fix_hit;
    logic [SEL_W-1:0]  cand;
    logic              grant;
    logic              load_en;
    logic [DATA_W-1:0] cand_data;
    int unsigned       idx;

    assign load_en = !out_valid || out_ready;

    // Round-robin search: first valid channel starting at ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_cand  = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_cand  = SEL_W'(idx);
            end
        end
    end

    // Fixed-mode decode; a sel beyond NUM_CH-1 matches no channel.
    always_comb begin
        sel_ok  = 1'b0;
        fix_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ok  = 1'b1;
                fix_hit = in_valid[i];
            end
        end
    end

    // Candidate/grant selection and the data of the chosen channel.
    always_comb begin
        cand      = mode ? rr_cand : sel;
        grant     = mode ? rr_found : fix_hit;
        cand_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cand == SEL_W'(i)) cand_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    // One-hot ready toward the granted channel; forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rst_n && load_en && grant && cand == SEL_W'(i)) in_ready[i] = 1'b1;
        end
    end

    // Output register stage: load on transfer, empty on idle, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_ch    <= cand;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances past the winner on RR transfers only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (mode && grant && load_en) begin
            ptr <= (cand == SEL_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
        end
    end

`ifdef MUX_RR_SEL_ERR_EN
    // Sticky flag for fixed-mode selection of a nonexistent channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (!mode && !sel_ok && |in_valid) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux_rr_sel.md
Name: mux_rr_sel

Overview:
Parametrised N-channel registered multiplexer with per-channel valid/ready handshake. It supersedes the combinational 4:1 mux.
- Two modes: fixed select (channel chosen by sel) and round-robin arbitration among valid channels.
- One output register stage.
- Sits between parallel producers and a single downstream consumer.

Parameters:
NUM_CH, 4, number of input channels (>=2)
DATA_W, 1, width of each channel's data
SEL_W, $clog2(NUM_CH), width of sel and out_ch

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  channel i holds data
in_ready  output  NUM_CH  channel i data accepted this cycle when in_valid[i] && in_ready[i]
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
out_data  output  DATA_W  registered selected data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
out_ch  output  SEL_W  index of channel that produced out_data

Behaviour:
- Reset (rst_n=0 at rising clk): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0, in_ready=0 during the reset cycle.
- load_en = !out_valid || out_ready (output slot free or draining this cycle).
- Grant:
  - Fixed mode: candidate = sel. Grant only if sel < NUM_CH and in_valid[sel].
  - RR mode: candidate = first index with in_valid set, searching ptr, ptr+1, ..., wrapping modulo NUM_CH. No grant if no in_valid bit is set.
- in_ready[i] = load_en && grant && (i == candidate). At most one in_ready bit is high. in_ready is combinational from in_valid/mode/sel/ptr/out_valid/out_ready.
- On transfer (grant && load_en) at rising clk: out_data <= selected data, out_ch <= candidate, out_valid <= 1.
- If load_en && !grant: out_valid <= 0. out_data and out_ch hold their previous values.
- If !load_en: all output registers hold. Data stays stable while out_valid && !out_ready.
- Latency: input accepted in cycle N appears on out_data in cycle N+1.
- Throughput: one transfer per cycle when out_ready is held high.
- ptr update:
  - Only on an RR-mode transfer: ptr <= candidate+1, wrapping to 0 after NUM_CH-1.
  - Fixed-mode transfers leave ptr unchanged.
- Mode or sel change while out_valid && !out_ready: the held output is unaffected. The new mode/sel applies at the next load_en cycle.
- sel >= NUM_CH (NUM_CH not a power of 2): no grant, all in_ready=0, no output produced.
- Reset asserted mid-transfer: reset wins. All state returns to reset values and no transfer completes that cycle.
- No combinational path from in_* to out_data/out_valid/out_ch.

Optional Feature:
Macro MUX_RR_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit), reset 0.
  - sel_err is sticky. It sets on any rising clk where mode=0, sel >= NUM_CH and at least one in_valid bit is set.
  - sel_err clears only on reset.
- Undefined: no sel_err port, no associated logic. All other behaviour is identical.

Test Plan:
- Fixed mode, NUM_CH=4, DATA_W=1, in_data=4'b1010 (ch0=0, ch1=1, ch2=0, ch3=1), all valid, out_ready=1, sel=0,1,2,3 on consecutive cycles -> out_data 0,1,0,1 with out_ch 0,1,2,3, each one cycle after its sel. Only in_ready[sel] is high each cycle.
- RR mode, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1. Exactly one in_ready bit high per cycle.
- RR mode, in_valid=4'b1001, ptr=1 after a ch0 transfer -> next grant is ch3, then ch0. Channels 1 and 2 are never granted.
- Backpressure: out_ready=0 for 3 cycles after a load of ch2 data=1 -> out_valid=1, out_data=1 and out_ch=2 held stable, all in_ready=0. On out_ready=1 the next channel is loaded the same cycle.
- Reset mid-stream: pull rst_n low for one cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, out_ch=0. First RR grant after reset is the lowest valid index from 0.
- With MUX_RR_SEL_ERR_EN defined and NUM_CH=3: mode=0, sel=3, in_valid=3'b111 -> no output, in_ready=0, sel_err=1 next cycle. sel_err stays 1 after sel returns to 0 until reset.
